// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg
//   Shared widths, opcodes, FSM state type and a decode helper for the
//   MEM stage of the 5-stage MIPS pipeline.
package memory_stage_pkg;

    localparam int DWIDTH         = 32;
    localparam int OPCODE_WIDTH   = 6;
    localparam int FUNCT_WIDTH    = 6;
    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [OPCODE_WIDTH-1:0] OP_LW = 6'h23;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW = 6'h2b;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_REQ  = 1'b1
    } ms_state_e;

    // True for the two opcodes that touch data memory.
    function automatic logic is_mem_op(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/memory_stage.sv
// memory_stage
//   MEM stage of the 5-stage MIPS pipeline. Non-memory ops are registered
//   straight through to WB (latency 1). LW/SW run a req/ack transaction on
//   the data memory; misaligned addresses and ack timeouts raise a one-cycle
//   fault with a non-writing WB slot.
// Ports
//   ms_i_clk / ms_i_rst_n        clock, async active-low reset
//   ms_i_ce, ms_i_opcode, ms_i_funct, ms_i_alu_value, ms_i_data_rt,
//   ms_i_rd_addr, ms_i_reg_write execute-stage results
//   ms_o_mem_req/we/addr/wdata   data-memory request (held until ack)
//   ms_i_mem_ack, ms_i_mem_rdata data-memory completion (1-cycle ack)
//   ms_o_ce, ms_o_wb_data, ms_o_rd_addr, ms_o_reg_write,
//   ms_o_opcode, ms_o_funct      registered WB-side outputs
//   ms_o_stall                   combinational hold for IF/ID/EX
//   ms_o_fault                   1-cycle pulse: misaligned or timeout
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int WAIT_MAX = 16
) (
    input  logic                      ms_i_clk,
    input  logic                      ms_i_rst_n,
    input  logic                      ms_i_ce,
    input  logic [OPCODE_WIDTH-1:0]   ms_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]    ms_i_funct,
    input  logic [DWIDTH-1:0]         ms_i_alu_value,
    input  logic [DWIDTH-1:0]         ms_i_data_rt,
    input  logic [REG_ADDR_WIDTH-1:0] ms_i_rd_addr,
    input  logic                      ms_i_reg_write,
    output logic                      ms_o_mem_req,
    output logic                      ms_o_mem_we,
    output logic [DWIDTH-1:0]         ms_o_mem_addr,
    output logic [DWIDTH-1:0]         ms_o_mem_wdata,
    input  logic                      ms_i_mem_ack,
    input  logic [DWIDTH-1:0]         ms_i_mem_rdata,
    output logic                      ms_o_ce,
    output logic [DWIDTH-1:0]         ms_o_wb_data,
    output logic [REG_ADDR_WIDTH-1:0] ms_o_rd_addr,
    output logic                      ms_o_reg_write,
    output logic [OPCODE_WIDTH-1:0]   ms_o_opcode,
    output logic [FUNCT_WIDTH-1:0]    ms_o_funct,
    output logic                      ms_o_stall,
    output logic                      ms_o_fault
);

    localparam int               CNT_W    = $clog2(WAIT_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    ms_state_e                 state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      mem_req_q;
    logic                      mem_we_q;
    logic [DWIDTH-1:0]         mem_addr_q;
    logic [DWIDTH-1:0]         mem_wdata_q;
    // Access context captured at acceptance; execute inputs are ignored in REQ.
    logic [REG_ADDR_WIDTH-1:0] acc_rd_q;
    logic                      acc_reg_write_q;
    logic [OPCODE_WIDTH-1:0]   acc_opcode_q;
    logic [FUNCT_WIDTH-1:0]    acc_funct_q;
    logic                      ce_q;
    logic [DWIDTH-1:0]         wb_data_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      reg_write_q;
    logic [OPCODE_WIDTH-1:0]   opcode_q;
    logic [FUNCT_WIDTH-1:0]    funct_q;
    logic                      fault_q;

    logic in_idle, in_req, mem_op, aligned, accept, last_wait;

    assign in_idle   = (state_q == MS_IDLE);
    assign in_req    = (state_q == MS_REQ);
    assign mem_op    = ms_i_ce && is_mem_op(ms_i_opcode);
    assign aligned   = (ms_i_alu_value[1:0] == 2'b00);
    assign accept    = in_idle && mem_op && aligned;
    assign last_wait = (cnt_q == CNT_LAST);

    // NOTE: stall is combinational so it drops in the ack/timeout cycle itself,
    // letting upstream advance on the same edge the access completes.
    assign ms_o_stall = accept || (in_req && !ms_i_mem_ack && !last_wait);

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge ms_i_clk or negedge ms_i_rst_n) begin
        if (!ms_i_rst_n) begin
            state_q         <= MS_IDLE;
            cnt_q           <= '0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            acc_rd_q        <= '0;
            acc_reg_write_q <= 1'b0;
            acc_opcode_q    <= '0;
            acc_funct_q     <= '0;
            ce_q            <= 1'b0;
            wb_data_q       <= '0;
            rd_q            <= '0;
            reg_write_q     <= 1'b0;
            opcode_q        <= '0;
            funct_q         <= '0;
            fault_q         <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                MS_IDLE: begin
                    if (!ms_i_ce) begin
                        ce_q        <= 1'b0;
                        wb_data_q   <= '0;
                        rd_q        <= '0;
                        reg_write_q <= 1'b0;
                        opcode_q    <= '0;
                        funct_q     <= '0;
                    end else if (mem_op && !aligned) begin
                        // Misaligned: retire a non-writing slot and flag it.
                        ce_q        <= 1'b1;
                        wb_data_q   <= '0;
                        rd_q        <= ms_i_rd_addr;
                        reg_write_q <= 1'b0;
                        opcode_q    <= ms_i_opcode;
                        funct_q     <= ms_i_funct;
                        fault_q     <= 1'b1;
                    end else if (mem_op) begin
                        state_q         <= MS_REQ;
                        cnt_q           <= '0;
                        mem_req_q       <= 1'b1;
                        mem_we_q        <= (ms_i_opcode == OP_SW);
                        mem_addr_q      <= {ms_i_alu_value[DWIDTH-1:2], 2'b00};
                        mem_wdata_q     <= ms_i_data_rt;
                        acc_rd_q        <= ms_i_rd_addr;
                        acc_reg_write_q <= ms_i_reg_write;
                        acc_opcode_q    <= ms_i_opcode;
                        acc_funct_q     <= ms_i_funct;
                        ce_q            <= 1'b0;
                        wb_data_q       <= '0;
                        rd_q            <= '0;
                        reg_write_q     <= 1'b0;
                        opcode_q        <= '0;
                        funct_q         <= '0;
                    end else begin
                        ce_q        <= 1'b1;
                        wb_data_q   <= ms_i_alu_value;
                        rd_q        <= ms_i_rd_addr;
                        reg_write_q <= ms_i_reg_write;
                        opcode_q    <= ms_i_opcode;
                        funct_q     <= ms_i_funct;
                    end
                end
                MS_REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (ms_i_mem_ack || last_wait) begin
                        state_q   <= MS_IDLE;
                        mem_req_q <= 1'b0;
                        ce_q      <= 1'b1;
                        rd_q      <= acc_rd_q;
                        opcode_q  <= acc_opcode_q;
                        funct_q   <= acc_funct_q;
                        if (ms_i_mem_ack && !mem_we_q) begin
                            wb_data_q   <= ms_i_mem_rdata;
                            reg_write_q <= acc_reg_write_q;
                        end else begin
                            wb_data_q   <= '0;
                            reg_write_q <= 1'b0;
                        end
                        fault_q <= !ms_i_mem_ack;
                    end
                end
                default: state_q <= MS_IDLE;
            endcase
        end
    end

    assign ms_o_mem_req   = mem_req_q;
    assign ms_o_mem_we    = mem_we_q;
    assign ms_o_mem_addr  = mem_addr_q;
    assign ms_o_mem_wdata = mem_wdata_q;
    assign ms_o_ce        = ce_q;
    assign ms_o_wb_data   = wb_data_q;
    assign ms_o_rd_addr   = rd_q;
    assign ms_o_reg_write = reg_write_q;
    assign ms_o_opcode    = opcode_q;
    assign ms_o_funct     = funct_q;
    assign ms_o_fault     = fault_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage
//   Self-checking bench for memory_stage. Expected WB results are pushed to a
//   scoreboard when an instruction is driven and popped whenever the DUT
//   presents ms_o_ce=1. The bench plays the data memory with a scripted ack.
module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int                     WAIT_MAX = 16;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 6'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI = 6'h0c;
    localparam logic [FUNCT_WIDTH-1:0]  FN_ADD  = 6'h20;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      ce;
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [FUNCT_WIDTH-1:0]    funct;
    logic [DWIDTH-1:0]         alu_value;
    logic [DWIDTH-1:0]         data_rt;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      reg_write;
    logic                      mem_req, mem_we, mem_ack;
    logic [DWIDTH-1:0]         mem_addr, mem_wdata, mem_rdata;
    logic                      o_ce, o_reg_write, o_stall, o_fault;
    logic [DWIDTH-1:0]         o_wb_data;
    logic [REG_ADDR_WIDTH-1:0] o_rd_addr;
    logic [OPCODE_WIDTH-1:0]   o_opcode;
    logic [FUNCT_WIDTH-1:0]    o_funct;

    typedef struct {
        logic [DWIDTH-1:0]         wb;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      rw;
        logic [OPCODE_WIDTH-1:0]   op;
        logic [FUNCT_WIDTH-1:0]    fn;
        logic                      fault;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    memory_stage #(.WAIT_MAX(WAIT_MAX)) dut (
        .ms_i_clk       (clk),
        .ms_i_rst_n     (rst_n),
        .ms_i_ce        (ce),
        .ms_i_opcode    (opcode),
        .ms_i_funct     (funct),
        .ms_i_alu_value (alu_value),
        .ms_i_data_rt   (data_rt),
        .ms_i_rd_addr   (rd_addr),
        .ms_i_reg_write (reg_write),
        .ms_o_mem_req   (mem_req),
        .ms_o_mem_we    (mem_we),
        .ms_o_mem_addr  (mem_addr),
        .ms_o_mem_wdata (mem_wdata),
        .ms_i_mem_ack   (mem_ack),
        .ms_i_mem_rdata (mem_rdata),
        .ms_o_ce        (o_ce),
        .ms_o_wb_data   (o_wb_data),
        .ms_o_rd_addr   (o_rd_addr),
        .ms_o_reg_write (o_reg_write),
        .ms_o_opcode    (o_opcode),
        .ms_o_funct     (o_funct),
        .ms_o_stall     (o_stall),
        .ms_o_fault     (o_fault)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic drive(input logic c, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] alu, input logic [31:0] rt,
                         input logic [4:0] rd, input logic rw);
        ce = c; opcode = op; funct = fn; alu_value = alu; data_rt = rt;
        rd_addr = rd; reg_write = rw;
    endtask

    task automatic push(input logic [31:0] wb, input logic [4:0] rd, input logic rw,
                        input logic [5:0] op, input logic [5:0] fn, input logic f);
        exp_t e;
        e.wb = wb; e.rd = rd; e.rw = rw; e.op = op; e.fn = fn; e.fault = f;
        sb.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every WB-valid slot must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && o_ce) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_ce", 32'(o_ce), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_data",   o_wb_data,          e.wb);
                check("rd_addr",   32'(o_rd_addr),     32'(e.rd));
                check("reg_write", 32'(o_reg_write),   32'(e.rw));
                check("opcode",    32'(o_opcode),      32'(e.op));
                check("funct",     32'(o_funct),       32'(e.fn));
                check("fault",     32'(o_fault),       32'(e.fault));
            end
        end
    end

    // Aligned LW/SW with the bench acting as memory. ack_after<0 = never ack;
    // otherwise ack is raised in req cycle ack_after (0 = first req cycle).
    task automatic mem_access(input string name, input logic [5:0] op,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] rdata, input logic [4:0] rd,
                              input int ack_after, input int exp_stall, input int exp_req);
        int   stall_cycles = 0;
        int   req_cycles   = 0;
        logic timed_out;
        logic is_load;
        timed_out = (ack_after < 0) || (ack_after >= WAIT_MAX);
        is_load   = (op == OP_LW);
        drive(1'b1, op, 6'h00, addr, data, rd, 1'b1);
        push((is_load && !timed_out) ? rdata : 32'h0, rd, is_load && !timed_out,
             op, 6'h00, timed_out);
        #1 if (o_stall) stall_cycles++;
        tick();
        check({name, "_req_rise"}, 32'(mem_req),  32'd1);
        check({name, "_we"},       32'(mem_we),   32'(!is_load));
        check({name, "_addr"},     mem_addr,      addr);
        if (!is_load) check({name, "_wdata"}, mem_wdata, data);
        // Execute inputs stay held during the access, as a stalled upstream would.
        for (int k = 0; k < 100 && mem_req; k++) begin
            req_cycles++;
            if (k == ack_after) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            #1 if (o_stall) stall_cycles++;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
        end
        idle();
        check({name, "_req_cycles"},   32'(req_cycles),   32'(exp_req));
        check({name, "_stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
        check({name, "_done_ce"},      32'(o_ce),         32'd1);
        #1 check({name, "_stall_after"}, 32'(o_stall), 32'd0);
        tick();
        check({name, "_fault_drop"}, 32'(o_fault), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        idle();
        repeat (3) tick();
        check("rst_ce",        32'(o_ce),        32'd0);
        check("rst_mem_req",   32'(mem_req),     32'd0);
        check("rst_stall",     32'(o_stall),     32'd0);
        check("rst_fault",     32'(o_fault),     32'd0);
        check("rst_wb_data",   o_wb_data,        32'd0);
        check("rst_reg_write", 32'(o_reg_write), 32'd0);
        rst_n = 1'b1;
        tick();

        // Stray ack while idle must not start anything.
        mem_ack = 1'b1;
        #1 check("idle_ack_stall", 32'(o_stall), 32'd0);
        tick();
        mem_ack = 1'b0;
        check("idle_ack_req", 32'(mem_req), 32'd0);
        check("idle_ack_ce",  32'(o_ce),    32'd0);

        // ADD with latency 1 and no stall.
        drive(1'b1, 6'h00, FN_ADD, 32'h0000_0042, 32'h0, 5'd5, 1'b1);
        push(32'h0000_0042, 5'd5, 1'b1, 6'h00, FN_ADD, 1'b0);
        #1 check("add_stall", 32'(o_stall), 32'd0);
        tick();
        idle();
        check("add_latency_ce", 32'(o_ce), 32'd1);
        #1 check("add_stall_after", 32'(o_stall), 32'd0);
        tick();
        check("bubble_ce",        32'(o_ce),        32'd0);
        check("bubble_wb_data",   o_wb_data,        32'd0);
        check("bubble_reg_write", 32'(o_reg_write), 32'd0);
        check("bubble_opcode",    32'(o_opcode),    32'd0);

        // Back-to-back non-memory ops with varied payloads.
        for (int i = 0; i < 8; i++) begin
            logic [5:0]  op;
            logic [5:0]  fn;
            logic [31:0] alu;
            logic [4:0]  rd;
            op  = (i % 3 == 0) ? 6'h00 : ((i % 3 == 1) ? OP_ADDI : OP_ANDI);
            fn  = 6'($urandom_range(0, 63));
            alu = $urandom;
            rd  = 5'($urandom_range(1, 31));
            drive(1'b1, op, fn, alu, 32'h0, rd, i[0]);
            push(alu, rd, i[0], op, fn, 1'b0);
            tick();
        end
        idle();
        tick();

        mem_access("lw_ack3",  OP_LW, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 5'd7,  3,  4,  4);
        mem_access("sw_ack0",  OP_SW, 32'h0000_0104, 32'h0000_0055, 32'hBAD0_BAD0, 5'd9,  0,  1,  1);
        mem_access("lw_tmo",   OP_LW, 32'h0000_0108, 32'h0,          32'h1234_5678, 5'd10, -1, 16, 16);
        mem_access("lw_ack15", OP_LW, 32'h0000_010C, 32'h0,          32'hCAFE_F00D, 5'd11, 15, 16, 16);

        // Misaligned load: no request, fault pulse, non-writing slot.
        drive(1'b1, OP_LW, 6'h00, 32'h0000_0102, 32'h0, 5'd12, 1'b1);
        push(32'h0, 5'd12, 1'b0, OP_LW, 6'h00, 1'b1);
        #1 check("mis_stall", 32'(o_stall), 32'd0);
        tick();
        idle();
        check("mis_req",   32'(mem_req), 32'd0);
        check("mis_fault", 32'(o_fault), 32'd1);
        tick();
        check("mis_fault_drop", 32'(o_fault), 32'd0);

        // Reset while a request is outstanding.
        drive(1'b1, OP_LW, 6'h00, 32'h0000_0200, 32'h0, 5'd13, 1'b1);
        tick();
        idle();
        tick();
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_req_drop", 32'(mem_req), 32'd0);
        check("rst_ce_drop", 32'(o_ce), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(1'b1, 6'h00, FN_ADD, 32'h0000_0777, 32'h0, 5'd3, 1'b1);
        push(32'h0000_0777, 5'd3, 1'b1, 6'h00, FN_ADD, 1'b0);
        tick();
        idle();
        check("post_rst_add_ce", 32'(o_ce), 32'd1);
        repeat (3) tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
